ucsbece154b_branch_resolve: RTL and testbench

Execute-stage resolver for the gshare/BTB fetch predictor; it is the update side of the predictor interface.
- Carries each fetched instruction's prediction metadata (PC, predicted taken, predicted target, PHT index) through D and E shadow registers.
- Compares the prediction against the actual outcome in E.
- Drives the predictor's PHT/BTB/GHR write ports, plus the mispredict flush and redirect PC for the hazard unit and fetch mux.

---
 rtl/ucsbece154b_branch_resolve_if.sv | 38 +++
 rtl/ucsbece154b_branch_resolve.sv | 77 +++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ucsbece154b_branch_resolve_if.sv
// ucsbece154b_branch_resolve_if: fetch metadata, hazard controls, E-stage outcome and predictor update bus
interface ucsbece154b_branch_resolve_if #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS = 5
);
  localparam int BW = $clog2(NUM_BTB_ENTRIES);
  logic [31:0] pc_i;
  logic BranchTaken_i;
  logic [31:0] BTBtarget_i;
  logic [NUM_GHR_BITS-1:0] PHTreadaddress_i;
  logic StallD_i;
  logic FlushD_i;
  logic FlushE_i;
  logic [6:0] op_i;
  logic BranchCond_i;
  logic [31:0] TargetE_i;
  logic PHTwe_o;
  logic PHTincrement_o;
  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
  logic BTB_we_o;
  logic [BW-1:0] BTBwriteaddress_o;
  logic [31:0] BTBwritedata_o;
  logic GHRreset_o;
  logic Mispredict_o;
  logic [31:0] PCredirect_o;
  modport master (
    output pc_i, BranchTaken_i, BTBtarget_i, PHTreadaddress_i, StallD_i, FlushD_i, FlushE_i,
           op_i, BranchCond_i, TargetE_i,
    input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o, BTB_we_o, BTBwriteaddress_o,
           BTBwritedata_o, GHRreset_o, Mispredict_o, PCredirect_o
  );
  modport slave (
    input  pc_i, BranchTaken_i, BTBtarget_i, PHTreadaddress_i, StallD_i, FlushD_i, FlushE_i,
           op_i, BranchCond_i, TargetE_i,
    output PHTwe_o, PHTincrement_o, PHTwriteaddress_o, BTB_we_o, BTBwriteaddress_o,
           BTBwritedata_o, GHRreset_o, Mispredict_o, PCredirect_o
  );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve: E-stage prediction check and predictor update; BRANCH_RESOLVE_STATS_EN adds branch/mispredict counters
module ucsbece154b_branch_resolve #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS = 5
) (
  input logic clk,
  input logic reset_i,
  ucsbece154b_branch_resolve_if.slave bus
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0] NumBranches_o,
  output logic [31:0] NumMispredicts_o
`endif
);
  localparam int BW = $clog2(NUM_BTB_ENTRIES);
  typedef struct packed {
    logic v;
    logic [31:0] pc;
    logic tk;
    logic [31:0] tgt;
    logic [NUM_GHR_BITS-1:0] idx;
  } shadow_t;
  shadow_t d_q, d_d, e_q, e_d;
  logic act, is_br, is_j, cti, act_taken, tgt_diff, mis;
  always_comb begin
    d_d = bus.StallD_i ? d_q : {1'b1, bus.pc_i, bus.BranchTaken_i, bus.BTBtarget_i, bus.PHTreadaddress_i};
    d_d.v = d_d.v & ~bus.FlushD_i;
    e_d = d_q;
    e_d.v = d_q.v & ~bus.FlushE_i;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      d_q <= '0;
      e_q <= '0;
    end else begin
      d_q <= d_d;
      e_q <= e_d;
    end
  end
  // every output is gated by act so bubbles and the reset cycle issue no writes
  always_comb begin
    act = e_q.v & ~reset_i;
    is_br = bus.op_i == 7'b1100011;
    is_j = (bus.op_i == 7'b1101111) | (bus.op_i == 7'b1100111);
    cti = is_br | is_j;
    act_taken = is_br ? bus.BranchCond_i : is_j;
    tgt_diff = bus.TargetE_i != e_q.tgt;
    mis = act & ((act_taken != e_q.tk) | (act_taken & tgt_diff));
    bus.Mispredict_o = mis;
    bus.PCredirect_o = !act ? 32'd0 : act_taken ? bus.TargetE_i : e_q.pc + 32'd4;
    bus.PHTwe_o = act & is_br;
    bus.PHTincrement_o = act & act_taken;
    bus.PHTwriteaddress_o = act ? e_q.idx : '0;
    bus.BTB_we_o = act & cti & act_taken & (~e_q.tk | tgt_diff);
    bus.BTBwriteaddress_o = act ? e_q.pc[BW+1:2] : '0;
    bus.BTBwritedata_o = act ? bus.TargetE_i : 32'd0;
    bus.GHRreset_o = mis & is_br;
  end
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] nb_q, nb_d, nm_q, nm_d;
  always_comb begin
    nb_d = (act & cti & (nb_q != 32'hFFFFFFFF)) ? nb_q + 32'd1 : nb_q;
    nm_d = (mis & (nm_q != 32'hFFFFFFFF)) ? nm_q + 32'd1 : nm_q;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      nb_q <= '0;
      nm_q <= '0;
    end else begin
      nb_q <= nb_d;
      nm_q <= nm_d;
    end
  end
  assign NumBranches_o = nb_q;
  assign NumMispredicts_o = nm_q;
`endif
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// tb_ucsbece154b_branch_resolve: directed vector table plus a back-to-back resolution sequence
module tb_ucsbece154b_branch_resolve;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, NC = 7'b0110011;
  logic clk = 1'b0;
  logic reset_i;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) bus ();
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] nb, nm;
`endif
  ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk(clk),
    .reset_i(reset_i),
    .bus(bus)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .NumBranches_o(nb),
    .NumMispredicts_o(nm)
`endif
  );
  typedef struct {
    string name;
    logic rst, st, fd, fe;
    logic [31:0] pc;
    logic tk;
    logic [31:0] tgt;
    logic [4:0] idx;
    logic [6:0] op;
    logic cond;
    logic [31:0] te;
    logic [78:0] exp;
  } vec_t;
  vec_t vt[$];
  function automatic logic [78:0] o(logic pw, logic inc, logic [4:0] pwa, logic bw, logic [4:0] bwa,
                                   logic [31:0] bwd, logic ghr, logic mis, logic [31:0] red);
    return {pw, inc, pwa, bw, bwa, bwd, ghr, mis, red};
  endfunction
  task automatic add(string name, logic rst, logic st, logic fd, logic fe, logic [31:0] pc, logic tk,
                     logic [31:0] tgt, logic [4:0] idx, logic [6:0] op, logic cond, logic [31:0] te,
                     logic [78:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.st = st; v.fd = fd; v.fe = fe; v.pc = pc; v.tk = tk; v.tgt = tgt;
    v.idx = idx; v.op = op; v.cond = cond; v.te = te; v.exp = exp;
    vt.push_back(v);
  endtask
  task automatic drive(logic rst, logic st, logic fd, logic fe, logic [31:0] pc, logic tk, logic [31:0] tgt,
                       logic [4:0] idx, logic [6:0] op, logic cond, logic [31:0] te);
    reset_i = rst; bus.StallD_i = st; bus.FlushD_i = fd; bus.FlushE_i = fe;
    bus.pc_i = pc; bus.BranchTaken_i = tk; bus.BTBtarget_i = tgt; bus.PHTreadaddress_i = idx;
    bus.op_i = op; bus.BranchCond_i = cond; bus.TargetE_i = te;
  endtask
  task automatic check(string name, logic [78:0] act, logic [78:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [78:0] outs();
    return {bus.PHTwe_o, bus.PHTincrement_o, bus.PHTwriteaddress_o, bus.BTB_we_o, bus.BTBwriteaddress_o,
            bus.BTBwritedata_o, bus.GHRreset_o, bus.Mispredict_o, bus.PCredirect_o};
  endfunction
  initial begin
    // each row: fetch-side inputs enter D, E-side inputs describe whatever sits in E this cycle
    add("rst0", 1,0,0,0, 32'h100, 1, 32'h0, 5'h00, BR, 1, 32'h0, '0);
    add("rst1", 1,0,0,0, 32'h100, 1, 32'h0, 5'h00, BR, 1, 32'h0, '0);
    add("post_rst0", 0,0,0,0, 32'h40, 1, 32'h80, 5'h0A, BR, 1, 32'h80, '0);
    add("post_rst1", 0,0,0,0, 32'h44, 1, 32'h90, 5'h03, BR, 1, 32'h80, '0);
    add("correct_br", 0,0,0,0, 32'h7C, 0, 32'h0, 5'h1F, BR, 1, 32'h80,
        o(1, 1, 5'h0A, 0, 5'd16, 32'h80, 0, 0, 32'h80));
    add("nt_mispredict", 0,0,0,0, 32'hFFFFFFFC, 1, 32'h1234, 5'h07, BR, 0, 32'h90,
        o(1, 0, 5'h03, 0, 5'd17, 32'h90, 1, 1, 32'h48));
    add("jalr_new_tgt", 0,0,0,0, 32'h200, 0, 32'h0, 5'h02, JALR, 0, 32'h200,
        o(0, 1, 5'h1F, 1, 5'd31, 32'h200, 0, 1, 32'h200));
    add("alias_wrap", 0,0,0,0, 32'h300, 1, 32'h400, 5'h04, NC, 1, 32'h55,
        o(0, 0, 5'h07, 0, 5'd31, 32'h55, 0, 1, 32'h0));
    add("noncti_ok", 0,1,0,1, 32'h500, 0, 32'h0, 5'h00, NC, 0, 32'h0,
        o(0, 0, 5'h02, 0, 5'd0, 32'h0, 0, 0, 32'h204));
    add("stall_bubble0", 0,1,0,1, 32'h504, 0, 32'h0, 5'h00, JAL, 0, 32'h400, '0);
    add("stall_bubble1", 0,0,0,0, 32'h600, 0, 32'h0, 5'h09, JAL, 0, 32'h400, '0);
    add("held_jal", 0,1,1,0, 32'h700, 1, 32'h0, 5'h00, JAL, 0, 32'h400,
        o(0, 1, 5'h04, 0, 5'd0, 32'h400, 0, 0, 32'h400));
    add("after_held", 0,0,0,0, 32'h40, 1, 32'h80, 5'h0A, NC, 0, 32'h0,
        o(0, 0, 5'h09, 0, 5'd0, 32'h0, 0, 0, 32'h604));
    add("stallflush_d", 0,0,0,0, 32'h800, 0, 32'h0, 5'h00, BR, 1, 32'h84, '0);
    add("mis_w_flush", 0,0,1,1, 32'h900, 0, 32'h0, 5'h00, BR, 1, 32'h84,
        o(1, 1, 5'h0A, 1, 5'd16, 32'h84, 1, 1, 32'h84));
    add("flushed_e", 0,0,0,0, 32'h40, 0, 32'h0, 5'h0A, BR, 1, 32'h84, '0);
    add("flushed_d", 0,0,0,0, 32'hA00, 0, 32'h0, 5'h00, BR, 1, 32'h84, '0);
    add("rst_mid", 1,0,0,0, 32'hB00, 0, 32'h0, 5'h00, BR, 1, 32'h84, '0);
    add("rst_mid_post0", 0,0,0,0, 32'hFFFFFFFC, 0, 32'h0, 5'h01, BR, 1, 32'h84, '0);
    add("rst_mid_post1", 0,0,0,0, 32'h0, 0, 32'h0, 5'h00, BR, 1, 32'h84, '0);
    add("jal_nt_pred", 0,0,0,0, 32'h0, 0, 32'h0, 5'h00, JAL, 0, 32'h8,
        o(0, 1, 5'h01, 1, 5'd31, 32'h8, 0, 1, 32'h8));
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 5'h0, NC, 0, 32'h0);
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].st, vt[i].fd, vt[i].fe, vt[i].pc, vt[i].tk, vt[i].tgt, vt[i].idx,
            vt[i].op, vt[i].cond, vt[i].te);
      #1 check(vt[i].name, outs(), vt[i].exp);
    end
    // back-to-back resolutions with no bubbles between them
    @(negedge clk); drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 5'h0, NC, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h10, 0, 32'h0, 5'h0, NC, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h14, 1, 32'h20, 5'h0, NC, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h18, 1, 32'h30, 5'h0, BR, 0, 32'h0);
    #1 check("b2b_a_mis", {78'd0, bus.Mispredict_o}, 79'd0);
    check("b2b_a_redir", {47'd0, bus.PCredirect_o}, {47'd0, 32'h14});
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 5'h0, BR, 1, 32'h20);
    #1 check("b2b_b_mis", {78'd0, bus.Mispredict_o}, 79'd0);
    check("b2b_b_redir", {47'd0, bus.PCredirect_o}, {47'd0, 32'h20});
    @(negedge clk); drive(0, 0, 0, 1, 32'h0, 0, 32'h0, 5'h0, JAL, 0, 32'h34);
    #1 check("b2b_c_mis", {78'd0, bus.Mispredict_o}, 79'd1);
    check("b2b_c_redir", {47'd0, bus.PCredirect_o}, {47'd0, 32'h34});
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 5'h0, NC, 0, 32'h0);
`ifdef BRANCH_RESOLVE_STATS_EN
    #1 check("num_branches", {47'd0, nb}, {47'd0, 32'd3});
    check("num_mispredicts", {47'd0, nm}, {47'd0, 32'd1});
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
